// File: rtl/alu_result_queue_if.sv
// ---------------------------------------------------------------------------
// alu_result_queue_if
// Bundles the ALU-side issue/result signals and the register-file writeback
// handshake of alu_result_queue.
//   Issue side   : RDY, DST (with RDY), SR (RDY+1), R/COUT/OVR/Zero/Sign (RDY+2)
//   Writeback    : WE, WDST, WDATA, WFLAGS out; WACK in
//   Status       : STALL (issue back-pressure), OVF (sticky overflow)
// Modports:
//   master - the environment (ALU issue logic + register file)
//   slave  - the queue itself
// ---------------------------------------------------------------------------
interface alu_result_queue_if #(
    parameter int DSTWidth = 4
);
    logic                RDY;
    logic [DSTWidth-1:0] DST;
    logic [1:0]          SR;
    logic [63:0]         R;
    logic [15:0]         COUT;
    logic                OVR;
    logic                Zero;
    logic                Sign;
    logic                WE;
    logic [DSTWidth-1:0] WDST;
    logic [63:0]         WDATA;
    logic [20:0]         WFLAGS;
    logic                WACK;
    logic                STALL;
    logic                OVF;

    modport master (
        output RDY, DST, SR, R, COUT, OVR, Zero, Sign, WACK,
        input  WE, WDST, WDATA, WFLAGS, STALL, OVF
    );

    modport slave (
        input  RDY, DST, SR, R, COUT, OVR, Zero, Sign, WACK,
        output WE, WDST, WDATA, WFLAGS, STALL, OVF
    );
endinterface

// File: rtl/alu_result_queue.sv
// ---------------------------------------------------------------------------
// alu_result_queue
// Collects ALU results whose fields arrive staggered after the issue strobe,
// assembles them into one writeback entry and forwards them in issue order
// through a small circular queue to the register file.
//
// Ports:
//   CLK    - clock, all state on the rising edge
//   RESET  - asynchronous active-high reset
//   bus    - alu_result_queue_if.slave: issue/result inputs, writeback
//            handshake (WE/WDST/WDATA/WFLAGS out, WACK in), STALL, OVF
//
// Parameters:
//   DSTWidth - destination tag width
//   DEPTH    - queue entries; 2, 4 or 8 (power of two so pointers wrap
//              naturally)
//
// Optional feature (macro ALURQ_BYPASS_EN): when defined, a result reaching
// stage 2 while the queue is empty is presented on the writeback port in
// that same cycle; if WACK is high it is consumed without being queued.
// Without the macro every result is written through the queue and the
// writeback outputs come only from stored entries.
//
// Entry layout: {dst, data[63:0], flags[20:0]},
//   flags = {SR[1:0], Sign, Zero, OVR, COUT[15:0]}
// ---------------------------------------------------------------------------
module alu_result_queue #(
    parameter int DSTWidth = 4,
    parameter int DEPTH    = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    alu_result_queue_if.slave bus
);
    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int EW   = DSTWidth + 64 + 21;

    // Alignment pipeline
    logic                s1_valid_reg;
    logic [DSTWidth-1:0] s1_dst_reg;
    logic                s2_valid_reg;
    logic [DSTWidth-1:0] s2_dst_reg;
    logic [1:0]          s2_sr_reg;

    // Queue control
    logic [PTRW-1:0]     wr_ptr_reg;
    logic [PTRW-1:0]     rd_ptr_reg;
    logic [CNTW-1:0]     count_reg;
    logic [CNTW-1:0]     count_next;
    logic                ovf_reg;

    // Entry storage; not reset, outputs are masked while empty
    logic [EW-1:0]       entry_reg [DEPTH];

    logic [EW-1:0]       s2_entry;
    logic [EW-1:0]       out_entry;
    logic                q_nonempty;
    logic                full;
    logic                bypass_take;
    logic                pop;
    logic                push;
    logic                wr_en;
    logic                drop;
    logic                we;

    // Stage 2 entry: tag and size from the pipeline, data/flags live on the bus
    assign s2_entry = {s2_dst_reg, bus.R, s2_sr_reg, bus.Sign, bus.Zero,
                       bus.OVR, bus.COUT};

    always_comb begin
        q_nonempty = (count_reg != '0);
        full       = (count_reg == CNTW'(DEPTH));
`ifdef ALURQ_BYPASS_EN
        bypass_take = !q_nonempty && s2_valid_reg;
`else
        bypass_take = 1'b0;
`endif
        pop   = q_nonempty && bus.WACK;
        // A bypassed result that is acknowledged never enters the queue
        push  = s2_valid_reg && !(bypass_take && bus.WACK);
        // When full, a same-cycle pop frees the slot being written
        wr_en = push && (!full || pop);
        drop  = push && full && !pop;

        count_next = count_reg;
        if (wr_en && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (pop && !wr_en) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_comb begin
        we        = 1'b0;
        out_entry = '0;
        if (q_nonempty) begin
            we        = 1'b1;
            out_entry = entry_reg[rd_ptr_reg];
        end
`ifdef ALURQ_BYPASS_EN
        else if (bypass_take) begin
            we        = 1'b1;
            out_entry = s2_entry;
        end
`endif
    end

    assign bus.WE     = we;
    assign bus.WDST   = out_entry[EW-1 -: DSTWidth];
    assign bus.WDATA  = out_entry[84:21];
    assign bus.WFLAGS = out_entry[20:0];
    assign bus.OVF    = ovf_reg;
    // Counts in-flight issues too, so an issuer that honours STALL can
    // never push into a full queue
    assign bus.STALL  = (int'(count_reg) + int'(s1_valid_reg)
                         + int'(s2_valid_reg)) >= DEPTH;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s1_valid_reg <= 1'b0;
            s1_dst_reg   <= '0;
            s2_valid_reg <= 1'b0;
            s2_dst_reg   <= '0;
            s2_sr_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            ovf_reg      <= 1'b0;
        end else begin
            s1_valid_reg <= bus.RDY;
            s1_dst_reg   <= bus.DST;
            s2_valid_reg <= s1_valid_reg;
            s2_dst_reg   <= s1_dst_reg;
            // SR belongs to the op sitting in stage 1 this cycle
            s2_sr_reg    <= bus.SR;
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
            if (drop) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            entry_reg[wr_ptr_reg] <= s2_entry;
        end
    end
endmodule

// File: tb/tb_alu_result_queue.sv
// ---------------------------------------------------------------------------
// tb_alu_result_queue
// Directed bench for alu_result_queue (DSTWidth=4, DEPTH=4). Issued ops are
// pushed to a scoreboard queue; each accepted writeback (WE && WACK) pops the
// oldest expected op and compares tag, data and flags. Latency expectations
// follow ALURQ_BYPASS_EN when it is defined for the build.
// ---------------------------------------------------------------------------
module tb_alu_result_queue;
    typedef struct packed {
        logic [3:0]  dst;
        logic [1:0]  sr;
        logic [63:0] r;
        logic [15:0] cout;
        logic        ovr;
        logic        zero;
        logic        sign;
    } op_t;

`ifdef ALURQ_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_result_queue_if #(.DSTWidth(4)) bus ();

    alu_result_queue #(
        .DSTWidth (4),
        .DEPTH    (4)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    op_t  sb[$];
    op_t  p1_op, p2_op, cur_op;
    logic p1_valid, p2_valid, cur_valid;

    function automatic op_t mk_op(input logic [3:0] dst);
        op_t o;
        o.dst  = dst;
        o.sr   = 2'($urandom);
        o.r    = {$urandom, $urandom};
        o.cout = 16'($urandom);
        o.ovr  = 1'($urandom);
        o.zero = 1'($urandom);
        o.sign = 1'($urandom);
        return o;
    endfunction

    function automatic logic [20:0] flags_of(input op_t o);
        return {o.sr, o.sign, o.zero, o.ovr, o.cout};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs (called just after the falling edge), then
    // score any writeback accepted in this cycle.
    task automatic drive(input logic rdy, input op_t op, input logic wack, input logic keep);
        op_t e;
        bus.RDY  = rdy;
        bus.DST  = rdy ? op.dst : 4'h0;
        bus.SR   = p1_valid ? p1_op.sr : 2'b00;
        bus.R    = p2_valid ? p2_op.r : 64'h0;
        bus.COUT = p2_valid ? p2_op.cout : 16'h0;
        bus.OVR  = p2_valid ? p2_op.ovr : 1'b0;
        bus.Zero = p2_valid ? p2_op.zero : 1'b0;
        bus.Sign = p2_valid ? p2_op.sign : 1'b0;
        bus.WACK = wack;
        cur_valid = rdy;
        cur_op    = op;
        if (rdy && keep) sb.push_back(op);
        #1;
        if (bus.WE && wack) begin
            if (sb.size() == 0) begin
                chk("unexpected_pop", 64'(bus.WE), 64'd0);
            end else begin
                e = sb.pop_front();
                $display("pop: WDST=%0h WDATA=%0h WFLAGS=%0h", bus.WDST, bus.WDATA, bus.WFLAGS);
                chk("wdst", 64'(bus.WDST), 64'(e.dst));
                chk("wdata", bus.WDATA, e.r);
                chk("wflags", 64'(bus.WFLAGS), 64'(flags_of(e)));
            end
        end
    endtask

    task automatic idle(input logic wack);
        drive(1'b0, '0, wack, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        p2_valid = p1_valid;
        p2_op    = p1_op;
        p1_valid = cur_valid;
        p1_op    = cur_op;
        @(negedge clk);
    endtask

    initial begin
        op_t op;
        rst = 1'b1;
        bus.RDY = 1'b0; bus.DST = '0; bus.SR = '0; bus.R = '0; bus.COUT = '0;
        bus.OVR = 1'b0; bus.Zero = 1'b0; bus.Sign = 1'b0; bus.WACK = 1'b0;
        p1_valid = 1'b0; p2_valid = 1'b0; cur_valid = 1'b0;
        p1_op = '0; p2_op = '0; cur_op = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_we", 64'(bus.WE), 64'd0);
        chk("reset_stall", 64'(bus.STALL), 64'd0);
        chk("reset_ovf", 64'(bus.OVF), 64'd0);
        chk("reset_wdst", 64'(bus.WDST), 64'd0);
        chk("reset_wdata", bus.WDATA, 64'd0);
        chk("reset_wflags", 64'(bus.WFLAGS), 64'd0);
        rst = 1'b0;

        // Single op latency
        op = '0; op.dst = 4'd3; op.sr = 2'b11; op.r = 64'h1234;
        drive(1'b1, op, 1'b1, 1'b1); chk("single_t0_we", 64'(bus.WE), 64'd0); tick();
        idle(1'b1); chk("single_t1_we", 64'(bus.WE), 64'd0); tick();
        idle(1'b1); chk("single_t2_we", 64'(bus.WE), 64'(BYP)); tick();
        idle(1'b1); chk("single_t3_we", 64'(bus.WE), 64'(!BYP)); tick();
        idle(1'b1); chk("single_t4_we", 64'(bus.WE), 64'd0); tick();

        // Burst of four with WACK low, then drain in order
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, mk_op(4'(i)), 1'b0, 1'b1);
            chk("burst_stall_pre", 64'(bus.STALL), 64'd0);
            tick();
        end
        idle(1'b0); chk("burst_stall", 64'(bus.STALL), 64'd1); tick();
        idle(1'b0); tick();
        idle(1'b0);
        chk("burst_full_we", 64'(bus.WE), 64'd1);
        chk("burst_full_wdst", 64'(bus.WDST), 64'd1);
        chk("burst_full_stall", 64'(bus.STALL), 64'd1);
        chk("burst_full_count", 64'(dut.count_reg), 64'd4);
        tick();
        for (int i = 0; i < 4; i++) begin idle(1'b1); tick(); end
        idle(1'b0);
        chk("burst_empty_we", 64'(bus.WE), 64'd0);
        chk("burst_empty_stall", 64'(bus.STALL), 64'd0);
        tick();

        // Full queue, push coinciding with pop
        for (int i = 5; i <= 8; i++) begin drive(1'b1, mk_op(4'(i)), 1'b0, 1'b1); tick(); end
        idle(1'b0); tick();
        idle(1'b0); tick();
        drive(1'b1, mk_op(4'd9), 1'b0, 1'b1); chk("full_stall", 64'(bus.STALL), 64'd1); tick();
        idle(1'b0); tick();
        idle(1'b1); tick();
        idle(1'b0);
        chk("pushpop_ovf", 64'(bus.OVF), 64'd0);
        chk("pushpop_wdst", 64'(bus.WDST), 64'd6);
        chk("pushpop_count", 64'(dut.count_reg), 64'd4);
        tick();

        // Full queue, forced issue without pop: entry dropped, OVF sticky
        drive(1'b1, mk_op(4'd10), 1'b0, 1'b0); tick();
        idle(1'b0); tick();
        idle(1'b0); chk("ovf_not_yet", 64'(bus.OVF), 64'd0); tick();
        idle(1'b0);
        chk("ovf_set", 64'(bus.OVF), 64'd1);
        chk("ovf_head", 64'(bus.WDST), 64'd6);
        tick();
        for (int i = 0; i < 4; i++) begin idle(1'b1); tick(); end
        idle(1'b0);
        chk("ovf_drained_we", 64'(bus.WE), 64'd0);
        chk("ovf_sticky", 64'(bus.OVF), 64'd1);
        tick();

        // Reset with two queued and one in flight
        drive(1'b1, mk_op(4'd11), 1'b0, 1'b1); tick();
        drive(1'b1, mk_op(4'd12), 1'b0, 1'b1); tick();
        idle(1'b0); tick();
        drive(1'b1, mk_op(4'd13), 1'b0, 1'b1); tick();
        idle(1'b0);
        chk("prerst_we", 64'(bus.WE), 64'd1);
        chk("prerst_stall", 64'(bus.STALL), 64'd0);
        rst = 1'b1;
        #1;
        chk("rst_we", 64'(bus.WE), 64'd0);
        chk("rst_stall", 64'(bus.STALL), 64'd0);
        chk("rst_ovf", 64'(bus.OVF), 64'd0);
        chk("rst_wdata", bus.WDATA, 64'd0);
        sb.delete();
        p1_valid = 1'b0; p2_valid = 1'b0; cur_valid = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle(1'b1); chk("postrst_we", 64'(bus.WE), 64'd0); tick();
        end

        // Mixed traffic honouring STALL
        for (int i = 0; i < 40; i++) begin
            drive(!bus.STALL && ($urandom_range(0, 2) != 0), mk_op(4'($urandom)),
                  1'($urandom_range(0, 1)), 1'b1);
            tick();
        end
        for (int i = 0; i < 12; i++) begin idle(1'b1); tick(); end
        idle(1'b0);
        chk("final_sb_empty", 64'(sb.size()), 64'd0);
        chk("final_we", 64'(bus.WE), 64'd0);
        chk("final_ovf", 64'(bus.OVF), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
